pixel_frame_loader: RTL and testbench

PIXEL_FRAME_LOADER -- requirements
Module: pixel_frame_loader

---
 rtl/fnn_pkg.sv | 15 +
 rtl/pix_convert.sv | 17 +
 rtl/pixel_frame_loader.sv | 102 ++++++++++
 tb/tb_pixel_frame_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// fnn_pkg: default frame geometry, launch FSM states and buffer-selection helper
// shared by the pixel frame loader blocks.
package fnn_pkg;
  localparam int DEF_N_PIX      = 784;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 11;
  localparam int DEF_FIRST_LEN  = 2;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} launch_state_t;

  // With both buffers full the write side already points back at the older one.
  function automatic logic oldest_full(input logic [1:0] full, input logic wsel);
    return &full ? wsel : full[1];
  endfunction
endpackage

// File: rtl/pix_convert.sv
// pix_convert: 8-bit pixel to DATA_WIDTH fixed-point word.
// PIX_NORM_EN defined: p/256 in Q format; undefined: binarised at 128.
module pix_convert
  import fnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic [7:0]            pix,
  output logic [DATA_WIDTH-1:0] word
);
`ifdef PIX_NORM_EN
  assign word = DATA_WIDTH'(pix) << (FRAC_BITS - 8);
`else
  assign word = (pix >= 8'd128) ? DATA_WIDTH'(1) << FRAC_BITS : '0;
`endif
endmodule

// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: ping-pong frame buffers feeding neural_net with a first/busy launch handshake.
// Pixel coding is selected by PIX_NORM_EN (see pix_convert).
module pixel_frame_loader
  import fnn_pkg::*;
#(
  parameter int N_PIX      = DEF_N_PIX,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int FIRST_LEN  = DEF_FIRST_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_valid,
  input  logic [7:0]                  pix_data,
  input  logic                        pix_last,
  output logic                        pix_ready,
  input  logic                        net_done,
  output logic [N_PIX*DATA_WIDTH-1:0] frame,
  output logic                        first,
  output logic                        busy,
  output logic                        frame_err
);
  localparam int CW = N_PIX > 1 ? $clog2(N_PIX) : 1;
  localparam int FW = FIRST_LEN > 1 ? $clog2(FIRST_LEN) : 1;

  launch_state_t state, state_d;
  logic [FW-1:0] fl_cnt, fl_d;
  logic [CW-1:0] fill_cnt;
  logic [1:0] full;
  logic wsel, rsel, rsel_d, clr;
  logic acc, at_end, done_f, err;
  logic [DATA_WIDTH-1:0] word;
  logic [N_PIX*DATA_WIDTH-1:0] fb_q [2];

  pix_convert #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_conv (
    .pix (pix_data),
    .word(word)
  );

  assign pix_ready = !full[wsel];
  assign acc       = pix_valid && pix_ready;
  assign at_end    = fill_cnt == CW'(N_PIX - 1);
  assign done_f    = acc && pix_last && at_end;
  assign err       = acc && (pix_last != at_end);
  assign frame     = fb_q[rsel];
  assign first     = state == LAUNCH;
  assign busy      = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      fl_cnt <= '0;
      rsel   <= 1'b0;
    end else begin
      state  <= state_d;
      fl_cnt <= fl_d;
      rsel   <= rsel_d;
    end
  end

  // A frame completing this edge launches straight from IDLE for one-cycle latency.
  always_comb begin
    state_d = state;
    fl_d    = fl_cnt;
    rsel_d  = rsel;
    clr     = 1'b0;
    case (state)
      IDLE: if (|full || done_f) begin
        state_d = LAUNCH;
        fl_d    = '0;
        rsel_d  = |full ? oldest_full(full, wsel) : wsel;
      end
      LAUNCH: begin
        fl_d    = fl_cnt + FW'(1);
        state_d = fl_cnt == FW'(FIRST_LEN - 1) ? BUSY : LAUNCH;
      end
      BUSY: if (net_done) begin
        state_d = IDLE;
        clr     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      full      <= '0;
      wsel      <= 1'b0;
      frame_err <= 1'b0;
      fb_q      <= '{default: '0};
    end else begin
      frame_err <= err;
      wsel      <= wsel ^ done_f;
      full      <= (full & ~(2'(clr) << rsel)) | (2'(done_f) << wsel);
      if (acc) begin
        fb_q[wsel][fill_cnt*DATA_WIDTH +: DATA_WIDTH] <= word;
        fill_cnt <= (done_f || err) ? '0 : fill_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pixel_frame_loader.sv
// tb_pixel_frame_loader: directed and randomized checks of pixel_frame_loader
// against a queue-of-frames reference model.
module tb_pixel_frame_loader;
  localparam int N = 784, DW = 16, FB = 11, FL = 2;
  localparam int FWID = N * DW;

  logic clk = 1'b0, rst_n = 1'b0, pix_valid = 1'b0, pix_last = 1'b0;
  logic nd_man = 1'b0, nd_auto = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic net_done, pix_ready, first, busy, frame_err;
  logic [FWID-1:0] frame;

  assign net_done = nd_man | nd_auto;
  always #5 clk = ~clk;

  pixel_frame_loader #(.N_PIX(N), .DATA_WIDTH(DW), .FRAC_BITS(FB), .FIRST_LEN(FL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_last (pix_last),
    .pix_ready(pix_ready),
    .net_done (net_done),
    .frame    (frame),
    .first    (first),
    .busy     (busy),
    .frame_err(frame_err)
  );

  int total = 0, bad = 0;
  bit chk_en = 0, auto_en = 0;
  int auto_dly = 0, acnt = 0;
  logic [7:0] pat [N];

  typedef struct {int slot; logic [7:0] pix; logic [15:0] exp;} vec_t;
  vec_t tv [8];

  function automatic logic [15:0] conv(input logic [7:0] p);
`ifdef PIX_NORM_EN
    return 16'(p) * 16'd8;
`else
    return p >= 8'd128 ? 16'h0800 : 16'h0000;
`endif
  endfunction

  // Reference: completed frames queue oldest-first; q[0] is the one shown while launched.
  logic [FWID-1:0] q [$];
  logic [FWID-1:0] cur;
  int cur_n, ph, rem;
  bit err_e, acc_m, fin_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); cur = '0; cur_n = 0; ph = 0; rem = 0; err_e = 0;
    end else begin
      acc_m = pix_valid && q.size() < 2;
      fin_m = 0;
      err_e = 0;
      if (acc_m) begin
        if (pix_last != (cur_n == N - 1)) begin
          err_e = 1; cur_n = 0;
        end else begin
          cur[cur_n*DW +: DW] = conv(pix_data);
          if (pix_last) begin fin_m = 1; cur_n = 0; end
          else cur_n++;
        end
      end
      if (ph == 0) begin
        if (q.size() > 0 || fin_m) begin ph = 1; rem = FL; end
      end else if (ph == 1) begin
        rem--;
        if (rem == 0) ph = 2;
      end else if (net_done) begin
        void'(q.pop_front());
        ph = 0;
      end
      if (fin_m) q.push_back(cur);
    end
  end

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_frame(input string nm, input logic [FWID-1:0] exp);
    total++;
    if (frame !== exp) begin
      bad++;
      for (int k = 0; k < N; k++)
        if (frame[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("FAIL %s slot=%0d got=%h exp=%h t=%0t", nm, k, frame[k*DW +: DW], exp[k*DW +: DW], $time);
          break;
        end
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk1("pix_ready", pix_ready, q.size() < 2);
    chk1("first", first, ph == 1);
    chk1("busy", busy, ph != 0);
    chk1("frame_err", frame_err, err_e);
    if (ph != 0) chk_frame("frame_launched", q[0]);
  end

  initial forever begin
    @(posedge clk); #1;
    nd_auto = 1'b0;
    if (auto_en && busy && !first) begin
      if (acnt >= auto_dly) begin nd_auto = 1'b1; acnt = 0; end
      else acnt++;
    end else acnt = 0;
  end

  task automatic abort(input string nm, input int waited);
    total++;
    bad++;
    $display("FAIL %s waited=%0d cycles limit exceeded", nm, waited);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pix(input logic [7:0] p, input logic last, input logic nd);
    int w = 0;
    pix_valid = 1'b1; pix_data = p; pix_last = last;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      @(posedge clk); #1;
      w++;
      if (w > 5000) abort("pix_ready_wait", w);
    end
    if (nd) nd_man = 1'b1;
    @(posedge clk); #1;
    if (nd) nd_man = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit last_f, input bit rnd, input int gap, input bit nd_last);
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(99)) < gap) begin pix_valid = 1'b0; @(posedge clk); #1; end
      send_pix(rnd ? 8'($urandom) : pat[k], last_f && k == n - 1, nd_last && k == n - 1);
    end
    pix_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic pulse_nd();
    nd_man = 1'b1;
    @(posedge clk); #1;
    nd_man = 1'b0;
  endtask

  task automatic drain();
    int w = 0, quiet = 0;
    auto_en = 1;
    while (quiet < 3) begin
      @(posedge clk); #1;
      quiet = (busy || first) ? 0 : quiet + 1;
      w++;
      if (w > 20000) abort("drain_idle", w);
    end
  endtask

  initial begin
`ifdef PIX_NORM_EN
    tv = '{'{0, 8'd0, 16'h0000}, '{1, 8'd1, 16'h0008}, '{127, 8'd127, 16'h03F8}, '{128, 8'd128, 16'h0400},
           '{255, 8'd255, 16'h07F8}, '{300, 8'd128, 16'h0400}, '{301, 8'd127, 16'h03F8}, '{783, 8'd200, 16'h0640}};
`else
    tv = '{'{0, 8'd0, 16'h0000}, '{1, 8'd1, 16'h0000}, '{127, 8'd127, 16'h0000}, '{128, 8'd128, 16'h0800},
           '{255, 8'd255, 16'h0800}, '{300, 8'd128, 16'h0800}, '{301, 8'd127, 16'h0000}, '{783, 8'd200, 16'h0800}};
`endif
    for (int k = 0; k < N; k++) pat[k] = 8'(k % 256);
    foreach (tv[i]) pat[tv[i].slot] = tv[i].pix;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    @(negedge clk);
    chk1("rst_pix_ready", pix_ready, 1'b1);
    chk1("rst_first", first, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk_frame("rst_frame", '0);
    @(posedge clk); #1;

    // single frame, late net_done
    auto_en = 1; auto_dly = 800;
    send_frame(N, 1, 0, 0, 0);
    chk1("t1_first_rise", first, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) chk16("t1_slot", frame[tv[i].slot*DW +: DW], tv[i].exp);
    step(1);
    chk1("t1_first_second", first, 1'b1);
    step(1);
    chk1("t1_first_fall", first, 1'b0);
    chk1("t1_busy_hold", busy, 1'b1);
    drain();

    // framing errors
    auto_dly = 5;
    send_frame(101, 1, 1, 0, 0);
    chk1("t2_err_early_last", frame_err, 1'b1);
    chk1("t2_no_first", first, 1'b0);
    step(1);
    chk1("t2_err_clear", frame_err, 1'b0);
    send_frame(N, 0, 1, 10, 0);
    chk1("t2_err_missing_last", frame_err, 1'b1);
    send_frame(N, 1, 1, 10, 0);
    chk1("t2_launch_after_err", first, 1'b1);
    drain();

    // back-to-back frames with net_done withheld
    auto_en = 0;
    send_frame(N, 1, 1, 0, 0);
    send_frame(N, 1, 1, 0, 0);
    fork
      send_frame(N, 1, 1, 0, 0);
      begin
        step(40);
        chk1("t3_blocked", pix_ready, 1'b0);
        chk1("t3_busy", busy, 1'b1);
        pulse_nd();
      end
    join
    drain();

    // net_done in IDLE, and coincident with a completing frame
    auto_en = 0;
    pulse_nd();
    chk1("t4_idle_nd_busy", busy, 1'b0);
    chk1("t4_idle_nd_ready", pix_ready, 1'b1);
    send_frame(N, 1, 1, 0, 0);
    step(5);
    send_frame(N, 1, 1, 0, 1);
    chk1("t4_coinc_busy", busy, 1'b0);
    chk1("t4_coinc_first", first, 1'b0);
    step(1);
    chk1("t4_relaunch_first", first, 1'b1);
    chk1("t4_relaunch_busy", busy, 1'b1);
    drain();

    // reset mid-frame while busy
    auto_en = 0;
    send_frame(N, 1, 1, 0, 0);
    send_frame(400, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk1("t5_first_clr", first, 1'b0);
    chk1("t5_busy_clr", busy, 1'b0);
    chk1("t5_ready", pix_ready, 1'b1);
    chk_frame("t5_frame_zero", '0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(20);
    chk1("t5_no_launch", busy, 1'b0);
    send_frame(N, 1, 1, 0, 0);
    chk1("t5_new_launch", first, 1'b1);
    drain();

    // randomized traffic
    for (int r = 0; r < 10; r++) begin
      auto_en = 1;
      auto_dly = $urandom_range(60);
      if ($urandom_range(3) == 0) send_frame($urandom_range(1, N - 1), 1, 1, 20, 0);
      else send_frame(N, 1, 1, $urandom_range(30), 0);
      if ($urandom_range(2) == 0) pulse_nd();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
